score_counter_display: RTL and testbench

- Parametrised successor to the two-digit score overlay.
- Owns the score as an N-digit BCD accumulator. Game logic submits increments over a valid/ready handshake.
- Emits a registered sprite-ROM hit flag and address for an optional label glyph plus N digit glyphs.
- Supports leading-zero blanking, saturation and a per-frame display snapshot so digits do not tear mid-frame.

---
 rtl/score_counter_display.sv | 221 ++++++++++++++++++++++
 tb/tb_score_counter_display.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/score_counter_display.sv
// N-digit BCD score accumulator with a valid/ready increment port and a
// registered sprite-ROM overlay (optional label glyph plus one glyph per digit).
module score_counter_display #(
    parameter int DIGITS        = 4,
    parameter int DIGIT_W       = 20,
    parameter int DIGIT_H       = 25,
    parameter int X_POS         = 180,
    parameter int Y_POS         = 16,
    parameter int LABEL_EN      = 1,
    parameter int LABEL_INDEX   = 11,
    parameter int BLANK_LEADING = 1,
    parameter int ADDR_W        = 15
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Clear,
    input  logic                  Add_Valid,
    input  logic [7:0]            Add_Value,
    output logic                  Add_Ready,
    input  logic [8:0]            PixelX,
    input  logic [8:0]            PixelY,
    output logic [4*DIGITS-1:0]   Score_BCD,
    output logic                  Saturated,
    output logic                  is_obj,
    output logic [ADDR_W-1:0]     Obj_address
);

    localparam int          SW       = 4 * DIGITS;
    localparam logic [31:0] GLYPH_SZ = 32'(DIGIT_W * DIGIT_H);
    localparam logic [31:0] DIGIT_X0 = 32'(X_POS + LABEL_EN * DIGIT_W);
    localparam logic [31:0] Y_TOP    = 32'(Y_POS);
    localparam logic [31:0] Y_BOT    = 32'(Y_POS + DIGIT_H);
    localparam logic [31:0] GLYPH_WU = 32'(DIGIT_W);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_STEP = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [7:0]      r_remaining;
    logic [7:0]      w_remaining_next;
    logic [SW-1:0]   r_score;
    logic [SW-1:0]   w_score_next;
    logic [SW-1:0]   w_score_inc;
    logic [SW-1:0]   r_snapshot;
    logic [DIGITS:0] w_carry;
    logic            w_all_nines;
    logic            w_accept;

    // ------------------------------------------------------------------
    // BCD +1 with full carry ripple; the final carry-out means all nines.
    // ------------------------------------------------------------------
    assign w_carry[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_bcd
            logic [3:0] w_digit;
            assign w_digit          = r_score[4*gi +: 4];
            assign w_carry[gi+1]    = w_carry[gi] && (w_digit == 4'd9);
            assign w_score_inc[4*gi +: 4] = !w_carry[gi]       ? w_digit :
                                            (w_digit == 4'd9)  ? 4'd0    :
                                                                 w_digit + 4'd1;
        end
    endgenerate

    assign w_all_nines = w_carry[DIGITS];
    assign Add_Ready   = (r_state == S_IDLE);
    assign w_accept    = Add_Valid && Add_Ready && !Clear;
    assign Score_BCD   = r_score;
    assign Saturated   = w_all_nines;

    // ------------------------------------------------------------------
    // Accumulator FSM
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state     <= S_IDLE;
            r_remaining <= 8'd0;
            r_score     <= '0;
        end else begin
            r_state     <= w_state_next;
            r_remaining <= w_remaining_next;
            r_score     <= w_score_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_remaining_next = r_remaining;
        w_score_next     = r_score;
        if (Clear) begin
            // Clear outranks everything, including a request offered this cycle.
            w_state_next     = S_IDLE;
            w_remaining_next = 8'd0;
            w_score_next     = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept && (Add_Value != 8'd0)) begin
                        w_remaining_next = Add_Value;
                        w_state_next     = S_STEP;
                    end
                end
                S_STEP: begin
                    if (!w_all_nines) begin
                        w_score_next = w_score_inc;
                    end
                    w_remaining_next = r_remaining - 8'd1;
                    if (r_remaining == 8'd1) begin
                        w_state_next = S_IDLE;
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Display snapshot, taken once per frame at the origin pixel
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_snapshot <= '0;
        end else if ((PixelX == 9'd0) && (PixelY == 9'd0)) begin
            r_snapshot <= r_score;
        end
    end

    // ------------------------------------------------------------------
    // Pixel decode
    // ------------------------------------------------------------------
    logic [31:0]       w_x;
    logic [31:0]       w_y;
    logic              w_in_rows;
    logic [31:0]       w_row_base;
    logic              w_label_hit;
    logic [ADDR_W-1:0] w_label_addr;
    logic [DIGITS-1:0] w_dig_hit;
    logic [DIGITS-1:0] w_dig_blank;
    logic [ADDR_W-1:0] w_dig_addr [DIGITS];
    logic              w_obj_next;
    logic [ADDR_W-1:0] w_addr_next;
    logic              r_is_obj;
    logic [ADDR_W-1:0] r_obj_address;

    assign w_x        = {23'd0, PixelX};
    assign w_y        = {23'd0, PixelY};
    assign w_in_rows  = (w_y >= Y_TOP) && (w_y < Y_BOT);
    assign w_row_base = (w_y - Y_TOP) * GLYPH_WU;

    generate
        if (LABEL_EN != 0) begin : g_label
            localparam logic [31:0] LABEL_LEFT = 32'(X_POS);
            localparam logic [31:0] LABEL_BASE = 32'(LABEL_INDEX * DIGIT_W * DIGIT_H);
            assign w_label_hit  = w_in_rows && (w_x >= LABEL_LEFT) &&
                                  (w_x < LABEL_LEFT + GLYPH_WU);
            assign w_label_addr = ADDR_W'(w_x - LABEL_LEFT + w_row_base + LABEL_BASE);
        end else begin : g_no_label
            assign w_label_hit  = 1'b0;
            assign w_label_addr = '0;
        end
    endgenerate

    // w_lead_zero[j] is set when digit columns 0..j (most significant first) are all zero.
    logic [DIGITS-2:0] w_lead_zero;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            localparam logic [31:0] LEFT = DIGIT_X0 + 32'(gi * DIGIT_W);
            logic [3:0] w_glyph;
            assign w_glyph        = r_snapshot[4*(DIGITS-1-gi) +: 4];
            assign w_dig_hit[gi]  = w_in_rows && (w_x >= LEFT) && (w_x < LEFT + GLYPH_WU);
            assign w_dig_addr[gi] = ADDR_W'(w_x - LEFT + w_row_base +
                                            {28'd0, w_glyph} * GLYPH_SZ);
            if (gi < DIGITS - 1) begin : g_lead
                if (gi == 0) begin : g_first
                    assign w_lead_zero[gi] = (w_glyph == 4'd0);
                end else begin : g_rest
                    assign w_lead_zero[gi] = w_lead_zero[gi-1] && (w_glyph == 4'd0);
                end
                assign w_dig_blank[gi] = (BLANK_LEADING != 0) && w_lead_zero[gi];
            end else begin : g_lsd
                assign w_dig_blank[gi] = 1'b0;
            end
        end
    endgenerate

    // Regions never overlap, so at most one branch below fires.
    always_comb begin
        w_obj_next  = 1'b0;
        w_addr_next = '0;
        if (w_label_hit) begin
            w_obj_next  = 1'b1;
            w_addr_next = w_label_addr;
        end
        for (int i = 0; i < DIGITS; i++) begin
            if (w_dig_hit[i] && !w_dig_blank[i]) begin
                w_obj_next  = 1'b1;
                w_addr_next = w_dig_addr[i];
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_is_obj      <= 1'b0;
            r_obj_address <= '0;
        end else begin
            r_is_obj      <= w_obj_next;
            r_obj_address <= w_addr_next;
        end
    end

    assign is_obj      = r_is_obj;
    assign Obj_address = r_obj_address;

endmodule

// File: tb/tb_score_counter_display.sv
// Scoreboard bench for score_counter_display: stimulus pushes expectations,
// a negedge monitor pops them when the DUT completes an add or presents a pixel.
module tb_score_counter_display;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Clear;
    logic        Add_Valid;
    logic [7:0]  Add_Value;
    logic        Add_Ready;
    logic [8:0]  PixelX;
    logic [8:0]  PixelY;
    logic [15:0] Score_BCD;
    logic        Saturated;
    logic        is_obj;
    logic [14:0] Obj_address;

    always #5 Clk = ~Clk;

    score_counter_display dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Clear       (Clear),
        .Add_Valid   (Add_Valid),
        .Add_Value   (Add_Value),
        .Add_Ready   (Add_Ready),
        .PixelX      (PixelX),
        .PixelY      (PixelY),
        .Score_BCD   (Score_BCD),
        .Saturated   (Saturated),
        .is_obj      (is_obj),
        .Obj_address (Obj_address)
    );

    typedef struct {
        logic [15:0] score;
        logic        sat;
        int          busy;
    } acc_exp_t;

    typedef struct {
        logic        obj;
        logic [14:0] addr;
        int          x;
        int          y;
    } pix_exp_t;

    acc_exp_t acc_q[$];
    pix_exp_t pix_q[$];
    int       tests_run    = 0;
    int       tests_failed = 0;
    int       busy_cnt     = 0;
    int       model        = 0;
    logic     pix_probe    = 1'b0;
    logic     pix_chk      = 1'b0;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int          t;
        t = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    always @(posedge Clk) pix_chk <= pix_probe;

    // Monitor: one line per observed transaction.
    always @(negedge Clk) begin : mon
        pix_exp_t pe;
        acc_exp_t ae;
        if (pix_chk) begin
            tests_run++;
            if (pix_q.size() == 0) begin
                tests_failed++;
                $display("FAIL pix_unexpected: obj=%0b addr=%0d with no expectation", is_obj, Obj_address);
            end else begin
                pe = pix_q.pop_front();
                if (is_obj !== pe.obj || Obj_address !== pe.addr) begin
                    tests_failed++;
                    $display("FAIL pix(%0d,%0d): got obj=%0b addr=%0d, expected obj=%0b addr=%0d",
                             pe.x, pe.y, is_obj, Obj_address, pe.obj, pe.addr);
                end else begin
                    $display("[TB] pix(%0d,%0d) obj=%0b addr=%0d ok", pe.x, pe.y, is_obj, Obj_address);
                end
            end
        end
        if (!Add_Ready) begin
            busy_cnt++;
        end else if (busy_cnt > 0) begin
            tests_run++;
            if (acc_q.size() == 0) begin
                tests_failed++;
                $display("FAIL acc_unexpected: score=%h busy=%0d with no expectation", Score_BCD, busy_cnt);
            end else begin
                ae = acc_q.pop_front();
                if (Score_BCD !== ae.score || Saturated !== ae.sat || busy_cnt != ae.busy) begin
                    tests_failed++;
                    $display("FAIL acc_done: got score=%h sat=%0b busy=%0d, expected score=%h sat=%0b busy=%0d",
                             Score_BCD, Saturated, busy_cnt, ae.score, ae.sat, ae.busy);
                end else begin
                    $display("[TB] add done score=%h sat=%0b busy=%0d ok", Score_BCD, Saturated, busy_cnt);
                end
            end
            busy_cnt = 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("[TB] %s = %0h ok", name, act);
        end
    endtask

    task automatic push_acc(input int score_bin, input int busy);
        acc_exp_t e;
        e.score = to_bcd(score_bin);
        e.sat   = (score_bin == 9999);
        e.busy  = busy;
        acc_q.push_back(e);
    endtask

    // Called at posedge+1; returns at posedge+1 once the DUT is idle again.
    task automatic add_req(input int k);
        int n;
        model = (model + k > 9999) ? 9999 : model + k;
        push_acc(model, k);
        Add_Valid = 1'b1;
        Add_Value = 8'(k);
        @(posedge Clk); #1;
        Add_Valid = 1'b0;
        n = 0;
        while (!Add_Ready && n < 400) begin
            @(posedge Clk); #1;
            n++;
        end
        if (!Add_Ready) begin
            tests_run++;
            tests_failed++;
            $display("FAIL add_timeout: Add_Ready still low after %0d cycles (k=%0d)", n, k);
        end
    endtask

    task automatic probe(input int x, input int y, input logic obj, input int addr);
        pix_exp_t e;
        e.obj  = obj;
        e.addr = 15'(addr);
        e.x    = x;
        e.y    = y;
        pix_q.push_back(e);
        PixelX    = 9'(x);
        PixelY    = 9'(y);
        pix_probe = 1'b1;
        @(posedge Clk); #1;
        pix_probe = 1'b0;
        PixelX    = 9'd400;
        PixelY    = 9'd300;
    endtask

    task automatic frame_start();
        PixelX = 9'd0;
        PixelY = 9'd0;
        @(posedge Clk); #1;
        PixelX = 9'd400;
        PixelY = 9'd300;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int step;
        Reset     = 1'b1;
        Clear     = 1'b0;
        Add_Valid = 1'b0;
        Add_Value = 8'd0;
        PixelX    = 9'd400;
        PixelY    = 9'd300;
        repeat (3) @(posedge Clk);
        #1;
        chk("reset_score", 32'(Score_BCD), 32'h0);
        chk("reset_sat", 32'(Saturated), 32'h0);
        chk("reset_ready", 32'(Add_Ready), 32'h1);
        chk("reset_is_obj", 32'(is_obj), 32'h0);
        chk("reset_addr", 32'(Obj_address), 32'h0);
        Reset = 1'b0;
        @(posedge Clk); #1;

        // Zero score: only the least significant digit is drawn.
        probe(260, 16, 1'b1, 0);
        probe(240, 16, 1'b0, 0);

        add_req(7);
        add_req(88);
        add_req(8);

        // Clear aborts a STEP after three increments.
        model = 0;
        push_acc(0, 4);
        Add_Valid = 1'b1;
        Add_Value = 8'd50;
        @(posedge Clk); #1;
        Add_Valid = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        Clear = 1'b1;
        @(posedge Clk); #1;
        Clear = 1'b0;
        chk("clear_abort_ready", 32'(Add_Ready), 32'h1);
        chk("clear_abort_score", 32'(Score_BCD), 32'h0);

        // Clear with a simultaneous request: request dropped.
        Clear     = 1'b1;
        Add_Valid = 1'b1;
        Add_Value = 8'd9;
        @(posedge Clk); #1;
        Clear     = 1'b0;
        Add_Valid = 1'b0;
        chk("clear_valid_ready", 32'(Add_Ready), 32'h1);
        @(posedge Clk); #1;
        chk("clear_valid_score", 32'(Score_BCD), 32'h0);

        // Climb to 9997, then saturate.
        while (model < 9997) begin
            step = (9997 - model > 255) ? 255 : 9997 - model;
            add_req(step);
        end
        chk("score_9997", 32'(Score_BCD), 32'h9997);
        add_req(5);
        add_req(3);
        chk("sat_hold", 32'(Saturated), 32'h1);

        Clear = 1'b1;
        @(posedge Clk); #1;
        Clear = 1'b0;
        model = 0;
        chk("clear_idle_score", 32'(Score_BCD), 32'h0);
        chk("clear_idle_sat", 32'(Saturated), 32'h0);

        // Snapshot 0x0042, then change the live score mid-frame.
        add_req(42);
        frame_start();
        add_req(1);
        probe(262, 16, 1'b1, 1002);
        probe(240, 16, 1'b1, 2000);
        probe(200, 16, 1'b0, 0);
        probe(220, 16, 1'b0, 0);
        probe(180, 16, 1'b1, 5500);
        probe(199, 40, 1'b1, 5999);
        probe(279, 40, 1'b1, 1499);
        probe(300, 16, 1'b0, 0);
        probe(279, 41, 1'b0, 0);
        probe(179, 16, 1'b0, 0);
        probe(280, 16, 1'b0, 0);
        frame_start();
        probe(262, 16, 1'b1, 1502);
        probe(240, 16, 1'b1, 2000);

        // Asynchronous reset in the middle of a STEP.
        model = 0;
        push_acc(0, 2);
        Add_Valid = 1'b1;
        Add_Value = 8'd50;
        @(posedge Clk); #1;
        Add_Valid = 1'b0;
        @(posedge Clk);
        @(posedge Clk);
        #3;
        Reset = 1'b1;
        #1;
        chk("async_reset_score", 32'(Score_BCD), 32'h0);
        chk("async_reset_ready", 32'(Add_Ready), 32'h1);
        chk("async_reset_sat", 32'(Saturated), 32'h0);
        @(posedge Clk); #1;
        Reset = 1'b0;
        @(posedge Clk); #1;
        probe(262, 16, 1'b1, 2);
        probe(240, 16, 1'b0, 0);

        repeat (5) @(posedge Clk);
        #1;
        chk("acc_queue_drained", 32'(acc_q.size()), 32'h0);
        chk("pix_queue_drained", 32'(pix_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
